// File: rtl/hangman_pkg.sv
// hangman_pkg: shared ASCII constants and guess_filter FSM state type
package hangman_pkg;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LZ    = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;
    localparam int         NUM_LETTERS = 26;
    typedef enum logic [1:0] {READY, ARMED, BUSY} gf_state_t;
endpackage

// File: rtl/ascii_classify.sv
// ascii_classify: letter detection, case folding and 0..25 letter index
module ascii_classify
    import hangman_pkg::*;
(
    input  logic [7:0] data,
    input  logic       case_fold,
    output logic       is_letter,
    output logic [7:0] folded,
    output logic [4:0] idx
);
    logic is_upper, is_lower;
    always_comb begin
        is_upper  = data >= ASCII_A && data <= ASCII_Z;
        is_lower  = case_fold && data >= ASCII_LA && data <= ASCII_LZ;
        is_letter = is_upper || is_lower;
        folded    = is_lower ? data - CASE_OFFSET : data;
        idx       = 5'(folded - ASCII_A);
    end
endmodule

// File: rtl/guess_filter.sv
// guess_filter: validates received bytes, buffers one new letter and issues it
// to the game logic as a single-cycle pulse when the game is ready.
module guess_filter
    import hangman_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 8,
    parameter int CASE_FOLD    = 1
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   game_rdy,
    input  logic                   red_busy,
    input  logic                   gameEnd,
    output logic [7:0]             guess,
    output logic                   pending,
    output logic                   dup,
    output logic                   invalid,
    output logic                   overrun,
    output logic                   timeout,
    output logic [NUM_LETTERS-1:0] guessed_mask
);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    gf_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    buf_letter, folded;
    logic [4:0]    idx;
    logic          is_letter, seen, accept, issue, tmo;

    ascii_classify u_cls (
        .data     (rx_data),
        .case_fold(CASE_FOLD != 0),
        .is_letter(is_letter),
        .folded   (folded),
        .idx      (idx)
    );

    assign seen   = is_letter && guessed_mask[idx];
    assign accept = rx_valid && is_letter && !seen && !pending;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        issue   = 1'b0;
        tmo     = 1'b0;
        case (state)
            READY: begin
                issue   = pending && game_rdy && !red_busy;
                state_d = issue ? ARMED : READY;
                cnt_d   = '0;
            end
            ARMED: begin
                // A finished game never raises red_busy, so give up after the window
                tmo     = !red_busy && cnt == CW'(BUSY_TIMEOUT - 1);
                state_d = red_busy ? BUSY : tmo ? READY : ARMED;
                cnt_d   = cnt + CW'(1);
            end
            BUSY:    state_d = (!red_busy && game_rdy) ? READY : BUSY;
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            state        <= READY;
            cnt          <= '0;
            guess        <= '0;
            pending      <= 1'b0;
            dup          <= 1'b0;
            invalid      <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            guessed_mask <= '0;
            buf_letter   <= '0;
        end else if (gameEnd) begin
            state        <= READY;
            cnt          <= '0;
            guess        <= '0;
            pending      <= 1'b0;
            dup          <= 1'b0;
            invalid      <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            guessed_mask <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            guess   <= issue ? buf_letter : 8'h00;
            timeout <= tmo;
            invalid <= rx_valid && !is_letter;
            dup     <= rx_valid && seen;
            overrun <= rx_valid && is_letter && !seen && pending;
            pending <= accept || (pending && !issue);
            if (accept) begin
                buf_letter        <= folded;
                guessed_mask[idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_guess_filter.sv
// tb_guess_filter: directed cases plus randomized traffic; expected events go
// into a queue that a negedge monitor drains as the DUT reports them.
module tb_guess_filter;
    localparam int TO = 8;

    logic        clk = 0, nRst = 1;
    logic [7:0]  rx_data = 0;
    logic        rx_valid = 0, game_rdy = 0, red_busy = 0, gameEnd = 0;
    logic [7:0]  guess;
    logic        pending, dup, invalid, overrun, timeout;
    logic [25:0] guessed_mask;

    int          errors = 0, checks = 0, cyc = 0;
    logic [10:0] exp_q[$];
    logic [25:0] m_mask = 0;
    logic        m_pend = 0;
    logic [7:0]  m_buf = 0;

    guess_filter #(.BUSY_TIMEOUT(TO), .CASE_FOLD(1)) dut (
        .clk(clk), .nRst(nRst), .rx_data(rx_data), .rx_valid(rx_valid),
        .game_rdy(game_rdy), .red_busy(red_busy), .gameEnd(gameEnd),
        .guess(guess), .pending(pending), .dup(dup), .invalid(invalid),
        .overrun(overrun), .timeout(timeout), .guessed_mask(guessed_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Event encoding {kind, value}: 1 guess, 2 dup, 3 invalid, 4 overrun, 5 timeout
    task automatic pop_cmp(input string nm, input logic [10:0] got);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected event %0h expected none", nm, got);
        end else chk(nm, 32'(got), 32'(exp_q.pop_front()));
    endtask

    always @(negedge clk) if (!nRst) begin
        if (guess != 0) pop_cmp("guess_evt", {3'd1, guess});
        if (timeout)    pop_cmp("timeout_evt", {3'd5, 8'h00});
        if (dup)        pop_cmp("dup_evt", {3'd2, 8'h00});
        if (invalid)    pop_cmp("invalid_evt", {3'd3, 8'h00});
        if (overrun)    pop_cmp("overrun_evt", {3'd4, 8'h00});
    end

    function automatic logic [8:0] fold(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return {1'b1, b};
        if (b >= 8'h61 && b <= 8'h7A) return {1'b1, b - 8'd32};
        return 9'h0;
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] edges [8] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h41, 8'h5A, 8'h61, 8'h7A};
        case ($urandom_range(0, 3))
            0: return 8'(65 + $urandom_range(0, 25));
            1: return 8'(97 + $urandom_range(0, 25));
            2: return 8'($urandom_range(0, 255));
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    task automatic send(input logic [7:0] b);
        logic [8:0] f = fold(b);
        logic [4:0] i;
        rx_data  = b;
        rx_valid = 1;
        if (!f[8]) exp_q.push_back({3'd3, 8'h00});
        else begin
            i = 5'(f[7:0] - 8'h41);
            if (m_mask[i])   exp_q.push_back({3'd2, 8'h00});
            else if (m_pend) exp_q.push_back({3'd4, 8'h00});
            else begin
                m_pend    = 1;
                m_buf     = f[7:0];
                m_mask[i] = 1;
            end
        end
        @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic expect_issue();
        exp_q.push_back({3'd1, m_buf});
        m_pend = 0;
    endtask

    task automatic wait_guess(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (guess == 0 && n < 20);
        chk("guess_seen", 32'(guess != 0), 32'd1);
        t = cyc;
    endtask

    task automatic respond(input int n);
        int c = 0;
        if (n == 0) begin
            exp_q.push_back({3'd5, 8'h00});
            do begin
                @(negedge clk);
                c++;
            end while (!timeout && c < 40);
            chk("timeout_cycles", 32'(c), 32'(TO));
        end else begin
            red_busy = 1;
            repeat (n) @(negedge clk);
            red_busy = 0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic end_game(input logic [7:0] b);
        gameEnd  = 1;
        rx_valid = 1;
        rx_data  = b;
        m_pend   = 0;
        m_mask   = 0;
        @(negedge clk);
        gameEnd  = 0;
        rx_valid = 0;
        chk("end_pending", 32'(pending), 32'd0);
        chk("end_mask", 32'(guessed_mask), 32'd0);
        chk("end_quiet", 32'({guess, dup, invalid, overrun, timeout}), 32'd0);
    endtask

    initial begin
        int t0, t1;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'({guess, pending, dup, invalid, overrun, timeout}), 32'd0);
        chk("reset_mask", 32'(guessed_mask), 32'd0);
        nRst = 0;
        @(negedge clk);
        chk("post_reset_mask", 32'(guessed_mask), 32'd0);

        // lowercase letter folds and issues once
        game_rdy = 1;
        send(8'h62);
        chk("c1_pending", 32'(pending), 32'd1);
        expect_issue();
        wait_guess(t0);
        chk("c1_guess", 32'(guess), 32'h42);
        @(negedge clk);
        chk("c1_one_cycle", 32'(guess), 32'd0);
        chk("c1_mask", 32'(guessed_mask), 32'h2);
        respond(2);

        // duplicate and non-letter drops
        send(8'h42);
        send(8'h31);
        @(negedge clk);
        chk("c2_mask", 32'(guessed_mask), 32'h2);
        chk("c2_pending", 32'(pending), 32'd0);

        // overrun while buffer is held
        game_rdy = 0;
        send(8'h43);
        send(8'h44);
        chk("c3_pending", 32'(pending), 32'd1);
        expect_issue();
        game_rdy = 1;
        wait_guess(t0);
        chk("c3_guess", 32'(guess), 32'h43);
        chk("c3_mask_d", 32'(guessed_mask[3]), 32'd0);
        respond(2);

        // busy handshake then a second buffered letter
        game_rdy = 0;
        send(8'h45);
        expect_issue();
        game_rdy = 1;
        wait_guess(t0);
        red_busy = 1;
        send(8'h46);
        repeat (4) @(negedge clk);
        red_busy = 0;
        expect_issue();
        wait_guess(t1);
        chk("c4_gap_min", 32'(t1 - t0 >= 3), 32'd1);
        chk("c4_gap", 32'(t1 - t0), 32'd7);
        respond(1);

        // no busy response: timeout
        send(8'h47);
        expect_issue();
        wait_guess(t0);
        respond(0);
        chk("c5_mask_g", 32'(guessed_mask[6]), 32'd1);

        // end of game flushes buffer and mask
        game_rdy = 0;
        send(8'h48);
        end_game(8'h49);
        send(8'h48);
        chk("c6_reaccept", 32'(pending), 32'd1);
        chk("c6_mask", 32'(guessed_mask), 32'h80);
        expect_issue();
        game_rdy = 1;
        wait_guess(t0);
        respond(1);

        for (int k = 0; k < 40; k++) begin
            game_rdy = 0;
            if ($urandom_range(0, 5) == 0) end_game(rand_byte());
            send(rand_byte());
            if ($urandom_range(0, 1) == 1) send(rand_byte());
            chk("rnd_pending", 32'(pending), 32'(m_pend));
            chk("rnd_mask", 32'(guessed_mask), 32'(m_mask));
            if (m_pend) begin
                expect_issue();
                game_rdy = 1;
                wait_guess(t0);
                respond($urandom_range(0, 3));
            end
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/guess_filter.md
Name: guess_filter

Overview:
- Upstream stage of the game logic: takes raw bytes from the player-side UART receiver and produces the `guess` byte the game logic consumes.
- Validates and case-folds letters, rejects letters already guessed this game, and buffers one pending guess.
- Issues each guess as a single-cycle non-zero pulse only when the game logic reports ready and not busy.
- Tracks a 26-bit guessed-letter mask that the display path can read.

Parameters:
- BUSY_TIMEOUT, 8: cycles to wait in ARMED for red_busy to assert before abandoning the issue.
- CASE_FOLD, 1: when 1, 'a'-'z' are accepted and mapped to 'A'-'Z'; when 0, lowercase bytes are invalid.

Ports:
- clk  in  1  system clock
- nRst  in  1  reset; synchronous, active-high (1 = reset)
- rx_data  in  8  received byte, qualified by rx_valid
- rx_valid  in  1  one-cycle strobe, rx_data valid
- game_rdy  in  1  game logic can take a guess
- red_busy  in  1  game logic is comparing letters
- gameEnd  in  1  end of game: flush buffer, clear mask
- guess  out  8  uppercase ASCII for exactly one cycle per issued guess, else 0x00
- pending  out  1  buffer holds an unissued guess
- dup  out  1  one-cycle pulse: letter already guessed, byte dropped
- invalid  out  1  one-cycle pulse: byte not a letter, byte dropped
- overrun  out  1  one-cycle pulse: buffer full, byte dropped
- timeout  out  1  one-cycle pulse: ARMED expired without red_busy
- guessed_mask  out  26  bit i set = letter 'A'+i accepted this game

Behaviour:
- Clock and reset:
  - All outputs are registered.
  - Reset (nRst=1 at a clk edge): guess=0, all pulses=0, pending=0, guessed_mask=0, buf_letter=0, timeout counter=0, FSM=READY.
  - Reset mid-issue aborts with no guess emitted.
- Classification (combinational, byte sampled only when rx_valid=1):
  - 0x41-0x5A is a letter.
  - 0x61-0x7A is a letter only when CASE_FOLD=1; it is folded by subtracting 0x20.
  - Letter index = folded - 0x41, 5 bits, range 0..25.
  - Every other byte is invalid.
- Acceptance priority when rx_valid=1 and gameEnd=0 (first match wins):
  1. Invalid byte → invalid pulses.
  2. guessed_mask[idx]=1 → dup pulses.
  3. pending=1 → overrun pulses. This includes the issue cycle, because the buffer is still full when sampled.
  4. Otherwise: buf_letter←folded, pending←1, guessed_mask[idx]←1, all on the next edge.
- A dropped byte changes no state apart from its pulse.
- FSM states:
  - READY: when pending & game_rdy & ~red_busy, the next edge sets guess←buf_letter (high for exactly one cycle), pending←0, counter←0, state←ARMED.
  - ARMED:
    - guess returns to 0x00.
    - If red_busy=1 → BUSY.
    - Else counter increments; when counter=BUSY_TIMEOUT-1 → READY, with timeout pulsing one cycle. This covers a game already won or lost, where the logic ignores guesses.
  - BUSY: red_busy=0 & game_rdy=1 → READY.
- Issue timing: the minimum gap between two issued guesses is 3 cycles (issue, ARMED, BUSY exit).
- New bytes may be accepted in any FSM state while pending=0.
- gameEnd=1 (highest priority after reset):
  - pending←0, guessed_mask←0, state←READY, counter←0, guess←0.
  - A same-cycle rx_valid byte is dropped silently, with no pulse.
- A timed-out letter stays set in guessed_mask; it is not re-issued.
- guess is never 0x00 when issued, so the consumer's "guess != 0" detection is unambiguous.

Decomposition:
- hangman_pkg:
  - ASCII_A=8'h41, ASCII_Z=8'h5A, ASCII_LA=8'h61, ASCII_LZ=8'h7A, CASE_OFFSET=8'h20, NUM_LETTERS=26.
  - enum gf_state_t {READY, ARMED, BUSY}.
- One combinational sub-module, ascii_classify (byte, case_fold → is_letter, folded[7:0], idx[4:0]). It is shared with the host word-entry path.
- Buffer, mask and FSM stay in guess_filter.

Test Plan:
1. Reset, then rx 0x62 with game_rdy=1, red_busy=0 → pending=1, then guess=0x42 for exactly one cycle, guessed_mask=26'h2.
2. After case 1, rx 0x42 → dup pulses once, no guess, mask unchanged. Rx 0x31 → invalid pulses.
3. With game_rdy=0, rx 0x43 then 0x44 → pending=1 and overrun on 0x44. Raise game_rdy → guess=0x43 only, mask bit 3 clear.
4. Issue 0x45, red_busy high 5 cycles, then game_rdy=1 → FSM ARMED→BUSY→READY; a buffered 0x46 issues no earlier than 3 cycles after 0x45.
5. Issue 0x47 with red_busy held 0 → timeout pulses after exactly BUSY_TIMEOUT cycles in ARMED, FSM=READY.
6. Buffer 0x48, then gameEnd together with rx 0x49 → pending=0, mask=0, no pulses, no guess. Rx 0x48 afterwards is accepted, not dup.
